// File: rtl/apb_regbank_slave.sv
// APB register bank: fifteen read/write registers plus a read-only STATUS word,
// with a setup/access phase monitor that counts protocol violations.
module apb_regbank_slave #(
    parameter int          SEL_INDEX = 0,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        err_flag
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state, state_nxt;
    logic        sel;
    logic [3:0]  idx;
    logic [3:0]  idx_p0;
    logic        write_p0;
    logic        latch, commit, proto_err;
    logic [31:0] regs [0:14];
    logic [15:0] wr_cnt, err_cnt, wr_cnt_nxt, err_cnt_nxt;
    logic [31:0] status, rd_val;
    logic        unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign sel         = psel[SEL_INDEX];
    assign idx         = paddr[5:2];
    assign unused_bits = ^{paddr[31:6], paddr[1:0], psel};
    assign status      = {wr_cnt, err_cnt};
    assign rd_val      = (idx == 4'd15) ? status : regs[idx];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        commit    = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                if (sel && !penable) begin
                    state_nxt = SETUP;
                    latch     = 1'b1;
                end else if (sel) begin
                    proto_err = 1'b1;
                end
            end
            SETUP: begin
                if (!sel) begin
                    proto_err = 1'b1;
                    state_nxt = IDLE;
                end else if (!penable) begin
                    // repeated setup: flag it but track the newest address/direction
                    proto_err = 1'b1;
                    latch     = 1'b1;
                end else if (idx == idx_p0 && pwrite == write_p0) begin
                    commit    = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    proto_err = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (!sel) begin
                    state_nxt = IDLE;
                end else if (!penable) begin
                    state_nxt = SETUP;
                    latch     = 1'b1;
                end else begin
                    proto_err = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Setup-phase capture (stage p0): address index and direction of the pending transfer
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            idx_p0   <= 4'd0;
            write_p0 <= 1'b0;
        end else if (latch) begin
            idx_p0   <= idx;
            write_p0 <= pwrite;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (commit && write_p0 && idx_p0 != 4'd15) begin
            regs[idx_p0] <= pwdata;
        end
    end

    // A STATUS write clears both counters and overrides its own write count.
    always_comb begin
        wr_cnt_nxt  = wr_cnt;
        err_cnt_nxt = err_cnt;
        if (commit && write_p0) begin
            if (idx_p0 == 4'd15) begin
                wr_cnt_nxt  = 16'd0;
                err_cnt_nxt = 16'd0;
            end else begin
                wr_cnt_nxt = sat_inc(wr_cnt);
            end
        end
        if (proto_err) begin
            err_cnt_nxt = sat_inc(err_cnt);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_cnt   <= 16'd0;
            err_cnt  <= 16'd0;
            err_flag <= 1'b0;
        end else begin
            wr_cnt   <= wr_cnt_nxt;
            err_cnt  <= err_cnt_nxt;
            err_flag <= (err_cnt_nxt != 16'd0);
        end
    end

    // Read data is captured in the setup cycle so it is stable for the whole access cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            prdata <= 32'd0;
        end else if (sel && !penable && !pwrite) begin
            prdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: directed vector table, reset-abort sequence,
// and randomized APB traffic checked against a behavioural model.
module tb_apb_regbank_slave;

    localparam int          SEL = 1;
    localparam logic [31:0] RV  = 32'h1234_5678;
    localparam int PH_IDLE = 0, PH_SETUP = 1, PH_ACC = 2;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        err_flag;

    int total = 0;
    int bad   = 0;

    apb_regbank_slave #(.SEL_INDEX(SEL), .RESET_VAL(RV)) dut (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .err_flag(err_flag)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [2:0]  ps;
        logic        pe;
        logic        pw;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_flag;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state
    logic [31:0] m_regs [0:15];
    logic [15:0] m_wr, m_err;
    logic [31:0] m_rd;
    logic        m_flag;
    int          m_ph;
    logic [3:0]  m_ix;
    logic        m_pw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] ps, input logic pe, input logic pw,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] er, input logic ef);
        vec_t v;
        v.ps = ps; v.pe = pe; v.pw = pw; v.ad = ad; v.wd = wd;
        v.exp_rd = er; v.exp_flag = ef;
        vecs.push_back(v);
    endtask

    task automatic drive_cycle(input logic [2:0] ps, input logic pe, input logic pw,
                               input logic [31:0] ad, input logic [31:0] wd);
        psel = ps; penable = pe; pwrite = pw; paddr = ad; pwdata = wd;
        @(posedge hclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = RV;
        m_wr = 16'd0; m_err = 16'd0; m_rd = 32'd0; m_flag = 1'b0;
        m_ph = PH_IDLE; m_ix = 4'd0; m_pw = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic pe, input logic pw,
                              input logic [3:0] ix, input logic [31:0] wd);
        logic [31:0] st;
        bit er, cm;
        st = {m_wr, m_err};
        er = 0; cm = 0;
        if (s && !pe && !pw) m_rd = (ix == 4'd15) ? st : m_regs[ix];
        case (m_ph)
            PH_IDLE: begin
                if (s && !pe) begin m_ph = PH_SETUP; m_ix = ix; m_pw = pw; end
                else if (s) er = 1;
            end
            PH_SETUP: begin
                if (!s) begin er = 1; m_ph = PH_IDLE; end
                else if (!pe) begin er = 1; m_ix = ix; m_pw = pw; end
                else if (ix == m_ix && pw == m_pw) begin cm = 1; m_ph = PH_ACC; end
                else begin er = 1; m_ph = PH_IDLE; end
            end
            default: begin
                if (!s) m_ph = PH_IDLE;
                else if (!pe) begin m_ph = PH_SETUP; m_ix = ix; m_pw = pw; end
                else begin er = 1; m_ph = PH_IDLE; end
            end
        endcase
        if (cm && m_pw) begin
            if (m_ix == 4'd15) begin
                m_wr = 16'd0; m_err = 16'd0;
            end else begin
                m_regs[m_ix] = wd;
                if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            end
        end
        if (er && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_flag = (m_err != 16'd0);
    endtask

    function automatic logic [2:0] mk_psel(input logic s);
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        v[SEL] = s;
        return v;
    endfunction

    function automatic logic [31:0] mk_addr(input logic [3:0] ix);
        logic [31:0] a;
        a = $urandom;
        a[5:2] = ix;
        return a;
    endfunction

    task automatic rcycle(input logic [2:0] ps, input logic pe, input logic pw,
                          input logic [31:0] ad, input logic [31:0] wd);
        drive_cycle(ps, pe, pw, ad, wd);
        model_step(ps[SEL], pe, pw, ad[5:2], wd);
        chk("rnd_prdata", prdata, m_rd);
        chk("rnd_err_flag", {31'd0, err_flag}, {31'd0, m_flag});
    endtask

    initial begin
        logic [3:0]  ix;
        logic        pw;
        logic [31:0] ad, wd;
        int          k;

        // reset read of index 3, then STATUS
        add(3'b010, 0, 0, 32'h0C, 0, RV, 0);
        add(3'b010, 1, 0, 32'h0C, 0, RV, 0);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0, 0);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0, 0);
        add(3'b000, 0, 0, 32'h0, 0, 32'h0, 0);
        // write 0x08 then back-to-back read, then STATUS
        add(3'b010, 0, 1, 32'h08, 32'hDEAD_BEEF, 32'h0, 0);
        add(3'b010, 1, 1, 32'h08, 32'hDEAD_BEEF, 32'h0, 0);
        add(3'b010, 0, 0, 32'h08, 0, 32'hDEAD_BEEF, 0);
        add(3'b010, 1, 0, 32'h08, 0, 32'hDEAD_BEEF, 0);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0001_0000, 0);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0001_0000, 0);
        add(3'b101, 0, 0, 32'h3C, 0, 32'h0001_0000, 0);
        // penable without setup, then setup followed by !sel
        add(3'b010, 1, 0, 32'h00, 0, 32'h0001_0000, 1);
        add(3'b010, 0, 0, 32'h10, 0, RV, 1);
        add(3'b000, 0, 0, 32'h10, 0, RV, 1);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0001_0002, 1);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0001_0002, 1);
        // setup at 0x04, access with 0x08
        add(3'b111, 0, 1, 32'h04, 32'hAAAA_5555, 32'h0001_0002, 1);
        add(3'b010, 1, 1, 32'h08, 32'hAAAA_5555, 32'h0001_0002, 1);
        add(3'b010, 0, 0, 32'h04, 0, RV, 1);
        add(3'b010, 1, 0, 32'h04, 0, RV, 1);
        add(3'b010, 0, 0, 32'h08, 0, 32'hDEAD_BEEF, 1);
        add(3'b010, 1, 0, 32'h08, 0, 32'hDEAD_BEEF, 1);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0001_0003, 1);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0001_0003, 1);
        // STATUS write clears both counters
        add(3'b010, 0, 1, 32'h3C, 32'h0, 32'h0001_0003, 1);
        add(3'b010, 1, 1, 32'h3C, 32'h0, 32'h0001_0003, 0);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0, 0);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0, 0);
        add(3'b000, 0, 0, 32'h0, 0, 32'h0, 0);
        // repeated setup re-latches as a read; then ACCESS followed by penable again
        add(3'b010, 0, 1, 32'h14, 32'h1111_1111, 32'h0, 0);
        add(3'b010, 0, 0, 32'h14, 0, RV, 1);
        add(3'b010, 1, 0, 32'h14, 0, RV, 1);
        add(3'b010, 0, 0, 32'h3C, 0, 32'h0000_0001, 1);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0000_0001, 1);
        add(3'b010, 1, 0, 32'h3C, 0, 32'h0000_0001, 1);
        add(3'b000, 0, 0, 32'h0, 0, 32'h0000_0001, 1);

        psel = 3'b000; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_prdata", prdata, 32'h0);
        chk("reset_err_flag", {31'd0, err_flag}, 32'h0);
        hresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].ps, vecs[i].pe, vecs[i].pw, vecs[i].ad, vecs[i].wd);
            if (prdata !== vecs[i].exp_rd || err_flag !== vecs[i].exp_flag) begin
                bad++;
                $display("FAIL vec_row%0d: got prdata=%h err_flag=%b expected prdata=%h err_flag=%b",
                         i, prdata, err_flag, vecs[i].exp_rd, vecs[i].exp_flag);
            end
            total++;
        end

        // reset between setup and access of a write discards the commit
        drive_cycle(3'b010, 0, 1, 32'h18, 32'hCAFE_F00D);
        hresetn = 1'b0;
        penable = 1'b1;
        #1;
        chk("abort_prdata_immediate", prdata, 32'h0);
        chk("abort_err_flag_immediate", {31'd0, err_flag}, 32'h0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        drive_cycle(3'b010, 1, 1, 32'h18, 32'hCAFE_F00D);
        chk("abort_access_is_error", {31'd0, err_flag}, 32'h1);
        chk("abort_access_prdata", prdata, 32'h0);
        drive_cycle(3'b010, 0, 0, 32'h18, 0);
        chk("abort_reg_kept", prdata, RV);
        drive_cycle(3'b010, 1, 0, 32'h18, 0);
        drive_cycle(3'b010, 0, 0, 32'h3C, 0);
        chk("abort_status", prdata, 32'h0000_0001);
        drive_cycle(3'b000, 0, 0, 0, 0);

        // randomized traffic against the model
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        model_reset();
        for (int t = 0; t < 400; t++) begin
            k  = $urandom_range(0, 9);
            ix = 4'($urandom_range(0, 15));
            pw = 1'($urandom_range(0, 1));
            if (pw && ix == 4'd15 && $urandom_range(0, 3) != 0) ix = 4'($urandom_range(0, 14));
            ad = mk_addr(ix);
            wd = $urandom;
            if (k <= 6) begin
                rcycle(mk_psel(1), 0, pw, ad, wd);
                rcycle(mk_psel(1), 1, pw, ad, wd);
                if ($urandom_range(0, 1) == 0) rcycle(mk_psel(0), 1'($urandom_range(0, 1)), 0, $urandom, $urandom);
            end else if (k == 7) begin
                rcycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            end else if (k == 8) begin
                rcycle(mk_psel(1), 0, pw, ad, wd);
                rcycle(mk_psel(1), 1, 1'($urandom_range(0, 1)), mk_addr(4'($urandom_range(0, 15))), wd);
            end else begin
                rcycle(mk_psel(1), 0, pw, ad, wd);
                rcycle(mk_psel(0), 0, pw, ad, wd);
            end
        end
        rcycle(3'b010, 0, 0, 32'h3C, 0);
        rcycle(3'b010, 1, 0, 32'h3C, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_regbank_slave.md
# apb_regbank_slave

APB peripheral register bank that sits directly downstream of the AHB-to-APB bridge. It responds to one bit of the bridge's three-bit peripheral select and drives read data back to the bridge. It holds fifteen read/write 32-bit registers and one read-only status register. A built-in phase monitor tracks the APB setup/access sequence and counts protocol violations.

## Interface
- SEL_INDEX, 0 — which bit of psel selects this slave (0..2)
- RESET_VAL, 32'h0000_0000 — reset value of every read/write register
- hclk  input  1  bridge clock; all state updates on the rising edge
- hresetn  input  1  asynchronous, active-low reset
- psel  input  3  one-hot peripheral select from the bridge; this slave uses psel[SEL_INDEX] (called sel below)
- penable  input  1  APB access-phase strobe
- pwrite  input  1  1 = write, 0 = read
- paddr  input  32  byte address; only paddr[5:2] (index) is decoded; other bits are ignored
- pwdata  input  32  write data
- prdata  output  32  registered read data
- err_flag  output  1  high while the protocol-error count is non-zero

## Operation
- Register map, by index = paddr[5:2]:
  - 0..14 (byte offsets 0x00–0x38): REG[i], read/write
  - 15 (byte offset 0x3C): STATUS, read-only value {wr_cnt[15:0], err_cnt[15:0]}
  - Any write to index 15 clears both counters; the write data is discarded.
- The phase FSM has three states: IDLE, SETUP, ACCESS. Reset state is IDLE.
  - IDLE:
    - sel & !penable → SETUP (latch index and pwrite).
    - sel & penable → error; stay in IDLE.
    - !sel → stay in IDLE.
  - SETUP:
    - sel & penable, with index and pwrite unchanged → ACCESS; commit (see below).
    - sel & penable, with index or pwrite changed → error; go to IDLE; no commit.
    - sel & !penable → error; stay in SETUP and re-latch index/pwrite.
    - !sel → error; go to IDLE.
  - ACCESS:
    - sel & !penable → SETUP (back-to-back transfer; latch).
    - !sel → IDLE.
    - sel & penable → error; go to IDLE.
- Commit, on the SETUP→ACCESS edge:
  - Write to index 0..14: REG[index] ← pwdata, and wr_cnt increments (saturates at 16'hFFFF).
  - Write to index 15: both counters are cleared. The clear takes priority over that write's own wr_cnt increment, so the result is 0.
  - Reads have no side effects.
- prdata:
  - Loaded at the end of any cycle where sel & !penable & !pwrite, from REG[index] or STATUS at that cycle.
  - Otherwise held. It is not cleared when sel drops.
- Error: err_cnt increments, saturating at 16'hFFFF. An error never coincides with a commit.
- err_flag = (err_cnt != 0), registered alongside err_cnt.
- The block is insensitive to psel bits other than SEL_INDEX. Multiple bits set is treated as sel = psel[SEL_INDEX].

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE
  - prdata = 0
  - REG[0..14] = RESET_VAL
  - wr_cnt = err_cnt = 0
  - err_flag = 0
- Reset asserted mid-transfer discards the pending commit. The first transfer after reset release needs a fresh setup phase.
- Read latency:
  - Setup cycle T: prdata is captured at the edge ending T and is valid throughout access cycle T+1, where the bridge samples it.
  - prdata stays stable until the next read setup.
- Write latency:
  - Register update at the edge ending the access cycle.
  - A read setup in the very next cycle (back-to-back) returns the new value.
- STATUS read in a setup cycle returns the counters as they stood at the start of that cycle.
- No wait states: every access completes in exactly one access cycle.
- Counters saturate; no wrap-around.

## Test plan
- Reset, then read index 3 and STATUS → prdata = RESET_VAL, then 32'h0000_0000; err_flag = 0.
- Write 32'hDEAD_BEEF to 0x08, then read back-to-back from 0x08 → prdata = 32'hDEAD_BEEF in the read's access cycle; STATUS = 32'h0001_0000.
- Assert penable with no preceding setup, then a setup followed by !sel → err_cnt = 2, err_flag = 1, no register changes.
- Setup at 0x04, then access with paddr = 0x08 → error, REG[1] and REG[2] unchanged, err_cnt increments.
- Write 32'h0 to 0x3C after several writes and errors → the next STATUS read = 0, and err_flag falls the cycle after the commit.
- Assert hresetn low between setup and access of a write → the register keeps RESET_VAL, and prdata/err_flag go to 0 immediately.
